// File: rtl/sequenciador_movimentos.sv
// Sequenciador de movimentos do Rubik's Polibot.
// Bufferiza códigos de movimento recebidos e os despacha ao executor.
`timescale 1ns/1ps

module sequenciador_movimentos #(
    parameter int MAX_MOVES   = 32,
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [7:0] rx_dado,
    input  logic       rx_pronto,
    input  logic       exec_fim,
    input  logic       tx_pronto,
    output logic       exec_partida,
    output logic [4:0] exec_movimento,
    output logic       tx_partida,
    output logic [7:0] tx_dado,
    output logic       pronto,
    output logic       fim,
    output logic       erro,
    output logic [3:0] db_estado
);

    localparam int CW = $clog2(MAX_MOVES + 1);
    localparam int PW = $clog2(MAX_MOVES);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [7:0] FIM_SEQ = 8'hFF;
    localparam logic [7:0] ST_OK   = 8'h4B;
    localparam logic [7:0] ST_ERRO = 8'h45;

    typedef enum logic [3:0] {
        INICIAL   = 4'h0,
        RECEBE    = 4'h1,
        PRONTO    = 4'h2,
        EXECUTA   = 4'h3,
        ESPERA    = 4'h4,
        PROXIMO   = 4'h5,
        TRANSMITE = 4'h6,
        ESPERA_TX = 4'h7,
        FIM       = 4'h8,
        ERRO      = 4'hE
    } estado_t;

    estado_t estado, proximo;

    logic [4:0]    buf_mem [MAX_MOVES];
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_nxt;
    logic [TW-1:0] timer;
    logic          byte_valido;
    logic          cheio;
    logic          ultimo;
    logic          estourou;
    logic          grava;
    logic [7:0]    status;

    // face 0..5, giro 1..3, bits altos zerados
    assign byte_valido = (rx_dado[7:5] == 3'd0) &&
                         (rx_dado[2:0] <= 3'd5) &&
                         (rx_dado[4:3] != 2'd0);
    assign cheio    = (count == CW'(MAX_MOVES));
    assign rd_nxt   = rd_ptr + PW'(1);
    assign ultimo   = ((CW'(rd_ptr) + CW'(1)) == count);
    assign estourou = (timer == TW'(TIMEOUT_CYC - 1));
    assign grava    = (estado == RECEBE) && rx_pronto &&
                      byte_valido && !cheio;
    assign status   = erro ? ST_ERRO : ST_OK;
    assign db_estado = estado;

    // registrador de estado
    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= INICIAL;
        else       estado <= proximo;
    end

    // próximo estado e saídas de controle
    always_comb begin
        proximo      = estado;
        exec_partida = 1'b0;
        tx_partida   = 1'b0;
        pronto       = 1'b0;
        fim          = 1'b0;
        case (estado)
            INICIAL: proximo = RECEBE;
            RECEBE: begin
                if (rx_pronto) begin
                    if (rx_dado == FIM_SEQ)
                        proximo = PRONTO;
                    else if (!byte_valido || cheio)
                        proximo = ERRO;
                end
            end
            PRONTO: begin
                pronto = 1'b1;
                if (iniciar)
                    proximo = (count == '0) ? TRANSMITE : EXECUTA;
            end
            EXECUTA: begin
                exec_partida = 1'b1;
                proximo      = ESPERA;
            end
            ESPERA: begin
                if (exec_fim)      proximo = PROXIMO;
                else if (estourou) proximo = ERRO;
            end
            PROXIMO: proximo = ultimo ? TRANSMITE : EXECUTA;
            TRANSMITE: begin
                tx_partida = 1'b1;
                proximo    = ESPERA_TX;
            end
            ESPERA_TX: if (tx_pronto) proximo = FIM;
            FIM: begin
                fim = 1'b1;
                if (iniciar) proximo = INICIAL;
            end
            ERRO:    proximo = TRANSMITE;
            default: proximo = INICIAL;
        endcase
    end

    // memória de movimentos; conteúdo não é inicializado
    always_ff @(posedge clock) begin
        if (grava) buf_mem[count[PW-1:0]] <= rx_dado[4:0];
    end

    // contadores, ponteiro, temporizador e registradores de saída
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count          <= '0;
            rd_ptr         <= '0;
            timer          <= '0;
            erro           <= 1'b0;
            exec_movimento <= 5'd0;
            tx_dado        <= 8'h00;
        end else begin
            case (estado)
                INICIAL: begin
                    count  <= '0;
                    rd_ptr <= '0;
                    erro   <= 1'b0;
                end
                RECEBE: if (grava) count <= count + CW'(1);
                PRONTO: begin
                    if (iniciar && count != '0)
                        exec_movimento <= buf_mem[rd_ptr];
                    else if (iniciar)
                        tx_dado <= status;
                end
                EXECUTA: timer <= '0;
                ESPERA:  timer <= timer + TW'(1);
                PROXIMO: begin
                    if (ultimo) begin
                        tx_dado <= status;
                    end else begin
                        rd_ptr         <= rd_nxt;
                        exec_movimento <= buf_mem[rd_nxt];
                    end
                end
                ERRO: begin
                    erro    <= 1'b1;
                    tx_dado <= ST_ERRO;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sequenciador_movimentos.sv
// Bancada do sequenciador de movimentos.
// Modelo de transação por sequência, estímulo aleatório.
`timescale 1ns/1ps

module tb_sequenciador_movimentos;

    localparam int MAXM = 4;
    localparam int TO   = 100;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic [7:0] rx_dado = 8'h00;
    logic       rx_pronto = 1'b0;
    logic       exec_fim = 1'b0;
    logic       tx_pronto = 1'b0;
    logic       exec_partida;
    logic [4:0] exec_movimento;
    logic       tx_partida;
    logic [7:0] tx_dado;
    logic       pronto;
    logic       fim;
    logic       erro;
    logic [3:0] db_estado;

    int total = 0;
    int bad   = 0;

    logic [7:0] bytes_q[$];
    int         k_q[$];

    sequenciador_movimentos #(
        .MAX_MOVES  (MAXM),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .iniciar       (iniciar),
        .rx_dado       (rx_dado),
        .rx_pronto     (rx_pronto),
        .exec_fim      (exec_fim),
        .tx_pronto     (tx_pronto),
        .exec_partida  (exec_partida),
        .exec_movimento(exec_movimento),
        .tx_partida    (tx_partida),
        .tx_dado       (tx_dado),
        .pronto        (pronto),
        .fim           (fim),
        .erro          (erro),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        iniciar   = 1'b0;
        rx_pronto = 1'b0;
        exec_fim  = 1'b0;
        tx_pronto = 1'b0;
    endtask

    function automatic bit valido(input logic [7:0] b);
        return (b < 8'h20) && ((b % 8) < 6) && ((b / 8) != 0);
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_partida"}, exec_partida, 0);
        chk({tag, "_mov"}, exec_movimento, 0);
        chk({tag, "_txp"}, tx_partida, 0);
        chk({tag, "_txd"}, tx_dado, 0);
        chk({tag, "_pronto"}, pronto, 0);
        chk({tag, "_fim"}, fim, 0);
        chk({tag, "_erro"}, erro, 0);
        chk({tag, "_st"}, db_estado, 0);
    endtask

    // chamado no ciclo em que TRANSMITE é esperado
    task automatic finish_tx(input bit e);
        int w;
        chk("st_tx", db_estado, 6);
        chk("tx_partida", tx_partida, 1);
        chk("tx_dado", tx_dado, e ? 8'h45 : 8'h4B);
        chk("erro_tx", erro, e);
        chk("partida_tx", exec_partida, 0);
        tick();
        chk("st_etx", db_estado, 7);
        chk("tx_partida_lo", tx_partida, 0);
        w = $urandom_range(0, 3);
        for (int i = 0; i < w; i++) begin
            exec_fim = 1'($urandom_range(0, 1));
            iniciar  = 1'($urandom_range(0, 1));
            tick();
            chk("st_etx_idle", db_estado, 7);
        end
        tx_pronto = 1'b1;
        tick();
        chk("st_fim", db_estado, 8);
        chk("fim", fim, 1);
        chk("erro_fim", erro, e);
        chk("pronto_fim", pronto, 0);
        w = $urandom_range(0, 2);
        for (int i = 0; i < w; i++) begin
            rx_pronto = 1'($urandom_range(0, 1));
            rx_dado   = 8'($urandom);
            exec_fim  = 1'($urandom_range(0, 1));
            tick();
            chk("st_fim_idle", db_estado, 8);
        end
        iniciar = 1'b1;
        tick();
        chk("st_ini", db_estado, 0);
        chk("fim_ini", fim, 0);
        tick();
        chk("st_rx0", db_estado, 1);
        chk("erro_clr", erro, 0);
    endtask

    // executa uma sequência completa a partir de RECEBE
    task automatic run_seq();
        logic [4:0] mv[$];
        logic [7:0] b;
        bit         err;
        bit         done;
        int         k;
        int         lim;
        err  = 1'b0;
        done = 1'b0;
        chk("st_rx", db_estado, 1);
        while (!done && !err && bytes_q.size() > 0) begin
            b = bytes_q.pop_front();
            repeat ($urandom_range(0, 2)) begin
                iniciar   = 1'($urandom_range(0, 1));
                exec_fim  = 1'($urandom_range(0, 1));
                tx_pronto = 1'($urandom_range(0, 1));
                tick();
                chk("st_rx_idle", db_estado, 1);
            end
            rx_dado   = b;
            rx_pronto = 1'b1;
            tick();
            if (b == 8'hFF) done = 1'b1;
            else if (valido(b) && mv.size() < MAXM) mv.push_back(b[4:0]);
            else err = 1'b1;
            chk("st_byte", db_estado, err ? 4'hE : (done ? 4'h2 : 4'h1));
        end
        bytes_q.delete();
        if (err) begin
            chk("erro_pre", erro, 0);
            tick();
            finish_tx(1'b1);
            k_q.delete();
            return;
        end
        chk("pronto", pronto, 1);
        repeat ($urandom_range(0, 2)) begin
            rx_pronto = 1'($urandom_range(0, 1));
            rx_dado   = 8'($urandom);
            exec_fim  = 1'($urandom_range(0, 1));
            tx_pronto = 1'($urandom_range(0, 1));
            tick();
            chk("st_pronto_idle", db_estado, 2);
        end
        iniciar = 1'b1;
        tick();
        if (mv.size() == 0) begin
            chk("no_partida", exec_partida, 0);
            finish_tx(1'b0);
            return;
        end
        for (int i = 0; i < mv.size(); i++) begin
            chk("st_exec", db_estado, 3);
            chk("partida", exec_partida, 1);
            chk("mov", exec_movimento, mv[i]);
            if (k_q.size() > 0) begin
                k = k_q.pop_front();
            end else begin
                lim = $urandom_range(0, 19);
                k = (lim == 0) ? 0 : (lim == 1) ? TO : $urandom_range(1, 6);
            end
            iniciar   = 1'($urandom_range(0, 1));
            rx_pronto = 1'($urandom_range(0, 1));
            rx_dado   = 8'($urandom);
            lim = (k == 0) ? TO : k;
            for (int c = 1; c <= lim; c++) begin
                tick();
                chk("st_espera", db_estado, 4);
                chk("partida_lo", exec_partida, 0);
                chk("mov_hold", exec_movimento, mv[i]);
                if (c == k) exec_fim = 1'b1;
            end
            tick();
            if (k == 0) begin
                chk("st_timeout", db_estado, 4'hE);
                tick();
                finish_tx(1'b1);
                k_q.delete();
                return;
            end
            chk("st_prox", db_estado, 5);
            tick();
        end
        finish_tx(1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        int n;
        #1 reset = 1'b1;
        #2 chk_zero("rst_async");
        tick();
        tick();
        chk_zero("rst");
        reset = 1'b0;
        tick();

        bytes_q = '{8'h08, 8'h0B, 8'h18, 8'hFF};
        k_q = '{5, 5, 5};
        run_seq();

        bytes_q = '{8'hFF};
        run_seq();

        bytes_q = '{8'h06, 8'hFF};
        run_seq();

        bytes_q = '{8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'hFF};
        run_seq();

        bytes_q = '{8'h08, 8'h11, 8'h1A, 8'h0D, 8'hFF};
        k_q = '{1, TO, 2, 3};
        run_seq();

        bytes_q = '{8'h10, 8'hFF};
        k_q = '{0};
        run_seq();

        rx_dado = 8'h0C;
        rx_pronto = 1'b1;
        tick();
        rx_dado = 8'hFF;
        rx_pronto = 1'b1;
        tick();
        chk("rst_pronto", db_estado, 2);
        iniciar = 1'b1;
        tick();
        chk("rst_partida", exec_partida, 1);
        chk("rst_mov", exec_movimento, 5'h0C);
        tick();
        chk("rst_espera", db_estado, 4);
        #2 reset = 1'b1;
        #1 chk_zero("rst_mid");
        tick();
        chk("rst_hold", db_estado, 0);
        reset = 1'b0;
        tick();
        chk("rst_rx", db_estado, 1);

        for (int s = 0; s < 30; s++) begin
            n = $urandom_range(0, 5);
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 99) < 88) begin
                    b = {3'b000, 2'($urandom_range(1, 3)),
                         3'($urandom_range(0, 5))};
                end else begin
                    b = 8'($urandom);
                    while (valido(b) || b == 8'hFF) b = 8'($urandom);
                end
                bytes_q.push_back(b);
            end
            bytes_q.push_back(8'hFF);
            run_seq();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
